// File: rtl/contador_bcd_n.sv
// rtl/contador_bcd_n.sv - N-digit BCD up/down counter with multiplexed 7-segment display scan
module contador_bcd_n #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 25_000_000,
   parameter int SCAN_DIV = 65536
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  blank_lz,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry,
   output logic [6:0]            seg_n,
   output logic [DIGITS-1:0]     an_n
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [4*DIGITS-1:0]   count_q, count_d;
   logic                  carry_q, carry_d;
   logic [SW-1:0]         scan_q, scan_d;
   logic [IW-1:0]         idx_q, idx_d;

   logic                  step;
   logic [4*DIGITS-1:0]   inc_val, dec_val, load_clean;
   logic                  inc_wrap, dec_wrap;
   logic [3:0]            dig, ld_dig, sel_dig;
   logic                  zero_from, blank;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'h40;
         4'd1:    seg_decode = 7'h79;
         4'd2:    seg_decode = 7'h24;
         4'd3:    seg_decode = 7'h30;
         4'd4:    seg_decode = 7'h19;
         4'd5:    seg_decode = 7'h12;
         4'd6:    seg_decode = 7'h02;
         4'd7:    seg_decode = 7'h78;
         4'd8:    seg_decode = 7'h00;
         4'd9:    seg_decode = 7'h10;
         default: seg_decode = 7'h7F;
      endcase
   endfunction

   assign step = en && (presc_q == PRE_MAX);

   // Prescaler: clear wins, otherwise free-run while enabled; load leaves it alone
   always_comb begin
      presc_d = presc_q;
      if (clr) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
      end
   end

   // Decimal increment/decrement candidates with digit ripple, plus sanitised load value
   always_comb begin
      logic c;
      logic b;
      c          = 1'b1;
      b          = 1'b1;
      dig        = '0;
      ld_dig     = '0;
      inc_val    = '0;
      dec_val    = '0;
      load_clean = '0;
      for (int k = 0; k < DIGITS; k++) begin
         dig = count_q[4*k +: 4];
         if (c) begin
            if (dig == 4'd9) begin
               inc_val[4*k +: 4] = 4'd0;
            end else begin
               inc_val[4*k +: 4] = dig + 4'd1;
               c = 1'b0;
            end
         end else begin
            inc_val[4*k +: 4] = dig;
         end
         if (b) begin
            if (dig == 4'd0) begin
               dec_val[4*k +: 4] = 4'd9;
            end else begin
               dec_val[4*k +: 4] = dig - 4'd1;
               b = 1'b0;
            end
         end else begin
            dec_val[4*k +: 4] = dig;
         end
         ld_dig = load_val[4*k +: 4];
         load_clean[4*k +: 4] = (ld_dig > 4'd9) ? 4'd0 : ld_dig;
      end
      inc_wrap = c;
      dec_wrap = b;
   end

   // Count next state: clear, then load, then step; carry only on a real wrap step
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_clean;
      end else if (step) begin
         if (up_dn) begin
            count_d = inc_val;
            carry_d = inc_wrap;
         end else begin
            count_d = dec_val;
            carry_d = dec_wrap;
         end
      end
   end

   // Free-running scan divider advancing the displayed digit index on each wrap
   always_comb begin
      scan_d = scan_q;
      idx_d  = idx_q;
      if (scan_q == SCAN_MAX) begin
         scan_d = '0;
         idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
         scan_d = scan_q + 1'b1;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         count_q <= '0;
         carry_q <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         carry_q <= carry_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
      end
   end

   // Select the scanned digit and decide whether it is a blankable leading zero
   always_comb begin
      zero_from = 1'b1;
      sel_dig   = '0;
      blank     = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_from = zero_from && (count_q[4*k +: 4] == 4'd0);
         if (idx_q == IW'(k)) begin
            sel_dig = count_q[4*k +: 4];
            blank   = blank_lz && (k != 0) && zero_from;
         end
      end
   end

   assign seg_n = blank ? 7'h7F : seg_decode(sel_dig);
   assign an_n  = ~(DIGITS'(1) << idx_q);
   assign count = count_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_contador_bcd_n.sv
// tb/tb_contador_bcd_n.sv - self-checking bench for contador_bcd_n (DIGITS=3, TICK_DIV=4, SCAN_DIV=2)
module tb_contador_bcd_n;

   localparam int D = 3;
   localparam int T = 4;
   localparam int S = 2;

   logic          clk = 1'b0;
   logic          rst_n, en, up_dn, clr, load, blank_lz;
   logic [11:0]   load_val;
   logic [11:0]   count;
   logic          carry;
   logic [6:0]    seg_n;
   logic [2:0]    an_n;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: count held as a plain integer 0..999
   int m_cnt, m_pre, m_scan, m_idx;
   bit m_carry;

   contador_bcd_n #(.DIGITS(D), .TICK_DIV(T), .SCAN_DIV(S)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .blank_lz(blank_lz), .count(count), .carry(carry),
      .seg_n(seg_n), .an_n(an_n)
   );

   always #5 clk = ~clk;

   function automatic int bcd_to_int(input logic [11:0] v);
      int r, p, d;
      r = 0;
      p = 1;
      for (int k = 0; k < D; k++) begin
         d = int'((v >> (4 * k)) & 12'hF);
         if (d > 9) d = 0;
         r += d * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [11:0] int_to_bcd(input int n);
      return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return tbl[d];
   endfunction

   function automatic logic [6:0] exp_seg();
      int p;
      p = (m_idx == 0) ? 1 : (m_idx == 1) ? 10 : 100;
      if (blank_lz && m_idx > 0 && m_cnt < p) return 7'h7F;
      return seg_of((m_cnt / p) % 10);
   endfunction

   function automatic logic [2:0] exp_an();
      return ~(3'b001 << m_idx);
   endfunction

   // one clock edge: advance the model from the inputs in force, then settle
   task automatic clk_cycle();
      bit stp;
      @(posedge clk);
      if (!rst_n) begin
         m_cnt = 0; m_pre = 0; m_scan = 0; m_idx = 0; m_carry = 0;
      end else begin
         stp     = en && (m_pre == T - 1);
         m_carry = 0;
         if (clr) m_pre = 0;
         else if (en) m_pre = (m_pre + 1) % T;
         if (clr) m_cnt = 0;
         else if (load) m_cnt = bcd_to_int(load_val);
         else if (stp) begin
            if (up_dn) begin
               if (m_cnt == 999) begin m_cnt = 0; m_carry = 1; end
               else m_cnt++;
            end else begin
               if (m_cnt == 0) begin m_cnt = 999; m_carry = 1; end
               else m_cnt--;
            end
         end
         if (m_scan == S - 1) begin m_scan = 0; m_idx = (m_idx + 1) % D; end
         else m_scan++;
      end
      #1;
   endtask

   task automatic do_load(input logic [11:0] v);
      load = 1'b1; load_val = v;
      clk_cycle();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 0; en = 1; up_dn = 1; clr = 0; load = 0; blank_lz = 0; load_val = 12'h999;
      clk_cycle();
      clk_cycle();
      vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL reset_count got %h want 000", count); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry got %b want 0", carry); end
      vectors++; if (seg_n !== 7'h40) begin miscompares++; $display("FAIL reset_seg got %h want 40", seg_n); end
      vectors++; if (an_n !== 3'b110) begin miscompares++; $display("FAIL reset_an got %b want 110", an_n); end
      rst_n = 1;
   endtask

   task automatic test_count_up();
      en = 1; up_dn = 1;
      for (int i = 1; i <= 8; i++) begin
         clk_cycle();
         vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL up_carry cyc %0d got %b want 0", i, carry); end
         if (i == 4) begin
            vectors++; if (count !== 12'h001) begin miscompares++; $display("FAIL up_4edges got %h want 001", count); end
         end
         if (i == 8) begin
            vectors++; if (count !== 12'h002) begin miscompares++; $display("FAIL up_8edges got %h want 002", count); end
         end
      end
   endtask

   task automatic test_wrap();
      int n;
      en = 1; up_dn = 1;
      do_load(12'h999);
      vectors++; if (count !== 12'h999) begin miscompares++; $display("FAIL wrap_load got %h want 999", count); end
      n = 0;
      while (count === 12'h999 && n < 8) begin clk_cycle(); n++; end
      vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL wrap_up_count got %h want 000", count); end
      vectors++; if (carry !== 1'b1) begin miscompares++; $display("FAIL wrap_up_carry got %b want 1", carry); end
      clk_cycle();
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL wrap_up_pulse got %b want 0", carry); end
      up_dn = 0;
      n = 0;
      while (count === 12'h000 && n < 8) begin clk_cycle(); n++; end
      vectors++; if (count !== 12'h999) begin miscompares++; $display("FAIL wrap_dn_count got %h want 999", count); end
      vectors++; if (carry !== 1'b1) begin miscompares++; $display("FAIL wrap_dn_carry got %b want 1", carry); end
      clk_cycle();
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL wrap_dn_pulse got %b want 0", carry); end
   endtask

   task automatic test_ripple_load();
      int n;
      en = 1; up_dn = 1;
      do_load(12'h019);
      n = 0;
      while (count === 12'h019 && n < 8) begin clk_cycle(); n++; end
      vectors++; if (count !== 12'h020) begin miscompares++; $display("FAIL ripple got %h want 020", count); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL ripple_carry got %b want 0", carry); end
      en = 0;
      do_load(12'h1A5);
      vectors++; if (count !== 12'h105) begin miscompares++; $display("FAIL load_bad_mid got %h want 105", count); end
      do_load(12'hFFF);
      vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL load_all_bad got %h want 000", count); end
      do_load(12'h9B9);
      vectors++; if (count !== 12'h909) begin miscompares++; $display("FAIL load_9b9 got %h want 909", count); end
   endtask

   task automatic test_priority();
      int n;
      en = 1; up_dn = 1;
      do_load(12'h456);
      n = 0;
      while (m_pre != T - 1 && n < 8) begin clk_cycle(); n++; end
      clr = 1; load = 1; load_val = 12'h123;
      clk_cycle();
      clr = 0; load = 0;
      vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL prio_clr got %h want 000", count); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL prio_clr_carry got %b want 0", carry); end
      for (int i = 1; i <= 4; i++) begin
         clk_cycle();
         vectors++;
         if (count !== ((i == 4) ? 12'h001 : 12'h000)) begin
            miscompares++; $display("FAIL prio_presc_cleared cyc %0d got %h want %h", i, count, (i == 4) ? 12'h001 : 12'h000);
         end
      end
      n = 0;
      while (m_pre != T - 1 && n < 8) begin clk_cycle(); n++; end
      do_load(12'h321);
      vectors++; if (count !== 12'h321) begin miscompares++; $display("FAIL prio_load_step got %h want 321", count); end
      vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL prio_load_carry got %b want 0", carry); end
      for (int i = 1; i <= 4; i++) begin
         clk_cycle();
         vectors++;
         if (count !== ((i == 4) ? 12'h322 : 12'h321)) begin
            miscompares++; $display("FAIL prio_presc_kept cyc %0d got %h want %h", i, count, (i == 4) ? 12'h322 : 12'h321);
         end
      end
   endtask

   task automatic test_display();
      logic [6:0] tbl_b [3];
      logic [6:0] tbl_n [3];
      tbl_b = '{7'h78, 7'h7F, 7'h7F};
      tbl_n = '{7'h78, 7'h40, 7'h40};
      en = 0;
      do_load(12'h007);
      for (int pass = 0; pass < 2; pass++) begin
         blank_lz = (pass == 0);
         for (int i = 0; i < 6; i++) begin
            clk_cycle();
            vectors++; if (an_n !== exp_an()) begin miscompares++; $display("FAIL disp_an got %b want %b", an_n, exp_an()); end
            vectors++;
            if (seg_n !== (blank_lz ? tbl_b[m_idx] : tbl_n[m_idx])) begin
               miscompares++; $display("FAIL disp_seg blank=%b idx=%0d got %h want %h", blank_lz, m_idx, seg_n, blank_lz ? tbl_b[m_idx] : tbl_n[m_idx]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      en = 1; up_dn = 1; blank_lz = 0;
      do_load(12'h250);
      for (int i = 0; i < 6; i++) clk_cycle();
      rst_n = 0; clr = 1; load = 1; load_val = 12'h999;
      clk_cycle();
      rst_n = 1; clr = 0; load = 0;
      vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL midrst_count got %h want 000", count); end
      vectors++; if (an_n !== 3'b110) begin miscompares++; $display("FAIL midrst_an got %b want 110", an_n); end
      vectors++; if (seg_n !== 7'h40) begin miscompares++; $display("FAIL midrst_seg got %h want 40", seg_n); end
      en = 1;
      clk_cycle();
      clk_cycle();
      en = 0;
      for (int i = 0; i < 8; i++) begin
         clk_cycle();
         vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL hold_count got %h want 000", count); end
         vectors++; if (an_n !== exp_an()) begin miscompares++; $display("FAIL hold_scan got %b want %b", an_n, exp_an()); end
      end
      en = 1;
      clk_cycle();
      vectors++; if (count !== 12'h000) begin miscompares++; $display("FAIL hold_resume1 got %h want 000", count); end
      clk_cycle();
      vectors++; if (count !== 12'h001) begin miscompares++; $display("FAIL hold_resume2 got %h want 001", count); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst_n    = ($urandom % 64) != 0;
         en       = ($urandom % 4) != 0;
         up_dn    = $urandom % 2;
         clr      = ($urandom % 32) == 0;
         load     = ($urandom % 16) == 0;
         blank_lz = $urandom % 2;
         case ($urandom % 4)
            0:       load_val = 12'h999;
            1:       load_val = 12'h000;
            2:       load_val = 12'h998;
            default: load_val = 12'($urandom);
         endcase
         clk_cycle();
         vectors++; if (count !== int_to_bcd(m_cnt)) begin miscompares++; $display("FAIL rnd_count cyc %0d got %h want %h", i, count, int_to_bcd(m_cnt)); end
         vectors++; if (carry !== m_carry) begin miscompares++; $display("FAIL rnd_carry cyc %0d got %b want %b", i, carry, m_carry); end
         vectors++; if (an_n !== exp_an()) begin miscompares++; $display("FAIL rnd_an cyc %0d got %b want %b", i, an_n, exp_an()); end
         vectors++; if (seg_n !== exp_seg()) begin miscompares++; $display("FAIL rnd_seg cyc %0d got %h want %h", i, seg_n, exp_seg()); end
      end
      rst_n = 1; clr = 0; load = 0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_ripple_load();
      test_priority();
      test_display();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
